aes_inv_cipher_iter: RTL and testbench

//  Iterative AES inverse cipher. Reuses one inverse-round datapath (InvShiftRows -> InvSubBytes
//  -> AddRound_Key -> InvMixColumns) for all NR rounds; the last round bypasses InvMixColumns.

---
 rtl/aes_inv_cipher_iter.sv | 130 +++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse-round datapath reused for all NR rounds per block.
// Round keys are read by index from an external key store that answers combinationally.
module aes_inv_cipher_iter #(
  parameter int NR = 10,
  parameter int KW = $clog2(NR+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic [KW-1:0] key_idx,
  input  logic [127:0]  round_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // InvMixColumns row 0 coefficients; row j uses the same set rotated right by j
  localparam logic [15:0] MIX_COEF = {4'd14, 4'd11, 4'd13, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm_q;
  logic [127:0]  state_q;
  logic [KW-1:0] rnd_q;
  logic [127:0]  round_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant, built from repeated doubling
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  // Byte i sits at row i%4, column i/4; InvShiftRows moves row r right by r columns
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0]   t [16];
    logic [7:0]   b;
    logic [127:0] r;
    int           src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src  = i % 4 + 4 * ((i / 4 - i % 4 + 4) % 4);
      b    = s[127 - 8*src -: 8];
      t[i] = INV_SBOX[2047 - 8*int'(b) -: 8] ^ k[127 - 8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        b = t[4*c + j];
        if (mix) begin
          b = 8'h00;
          for (int m = 0; m < 4; m++)
            b ^= gmul(t[4*c + m], MIX_COEF[15 - 4*((m - j + 4) % 4) -: 4]);
        end
        r[127 - 8*(4*c + j) -: 8] = b;
      end
    end
    return r;
  endfunction

  assign round_out = inv_round(state_q, round_key, rnd_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else if (flush) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_data ^ round_key;
            rnd_q   <= KW'(NR - 1);
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= round_out;
          if (rnd_q == '0) fsm_q <= DONE;
          else             rnd_q <= rnd_q - KW'(1);
        end
        DONE: begin
          // the result is handed off and the next block taken on the same edge
          if (out_ready) begin
            if (in_valid) begin
              state_q <= in_data ^ round_key;
              rnd_q   <= KW'(NR - 1);
              fsm_q   <= RUN;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign key_idx   = (fsm_q == RUN) ? rnd_q : KW'(NR);
  assign in_ready  = !flush && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors at NR=10 and NR=14, streaming,
// backpressure, flush and mid-block reset.
`timescale 1ns/1ps
module tb_aes_inv_cipher_iter;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rstN;
  logic         flushA, inValidA, inReadyA, outValidA, outReadyA, busyA;
  logic [127:0] inDataA, roundKeyA, outDataA;
  logic [3:0]   keyIdxA;
  logic         flushB, inValidB, inReadyB, outValidB, outReadyB, busyB;
  logic [127:0] inDataB, roundKeyB, outDataB;
  logic [3:0]   keyIdxB;
  logic [127:0] rkA [0:15];
  logic [127:0] rkB [0:15];
  logic [127:0] ptList [0:3];
  logic [127:0] ctList [0:3];
  int           checksRun;
  int           checksPassed;

  aes_inv_cipher_iter #(.NR(10)) dutA (
    .clk(clk), .rst_n(rstN), .flush(flushA), .in_valid(inValidA), .in_ready(inReadyA),
    .in_data(inDataA), .key_idx(keyIdxA), .round_key(roundKeyA), .out_valid(outValidA),
    .out_ready(outReadyA), .out_data(outDataA), .busy(busyA)
  );

  aes_inv_cipher_iter #(.NR(14)) dutB (
    .clk(clk), .rst_n(rstN), .flush(flushB), .in_valid(inValidB), .in_ready(inReadyB),
    .in_data(inDataB), .key_idx(keyIdxB), .round_key(roundKeyB), .out_valid(outValidB),
    .out_ready(outReadyB), .out_data(outDataB), .busy(busyB)
  );

  // Key stores answer combinationally to the requested index
  assign roundKeyA = rkA[keyIdxA];
  assign roundKeyB = rkB[keyIdxB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion; key is left-aligned in 256 bits, nk = 4 or 8 words
  task automatic expandKey(input logic [255:0] key, input int nk, input bit toB);
    logic [31:0] w [0:59];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subWord(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r <= nr; r++) begin
      if (toB) rkB[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rkA[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Forward AES-128 cipher with the key loaded for dutA, used to make fresh ciphertexts
  function automatic logic [127:0] encryptA(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rkA[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++)
        t[127 - 8*i -: 8] = sbox(s[127 - 8*(i % 4 + 4*((i/4 + i % 4) % 4)) -: 8]);
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 32*c -: 8];
          a1 = t[119 - 32*c -: 8];
          a2 = t[111 - 32*c -: 8];
          a3 = t[103 - 32*c -: 8];
          t[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          t[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          t[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          t[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      s = t ^ rkA[r];
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checksRun++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // One block through dutA or dutB with out_ready high; optionally tracks key_idx each cycle
  task automatic applyStimulus(input bit useB, input string tag, input logic [127:0] ct,
                               input logic [127:0] pt, input bit checkKeys);
    int nr;
    int edges;
    nr = useB ? 14 : 10;
    @(negedge clk);
    if (useB) begin inDataB = ct; inValidB = 1'b1; outReadyB = 1'b1; end
    else      begin inDataA = ct; inValidA = 1'b1; outReadyA = 1'b1; end
    edges = 0;
    while (!(useB ? inReadyB : inReadyA) && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (checkKeys) checkOutput({tag, "_kidx_idle"}, useB ? keyIdxB : keyIdxA, nr);
    @(posedge clk);
    @(negedge clk);
    inValidA = 1'b0;
    inValidB = 1'b0;
    edges = 0;
    while (!(useB ? outValidB : outValidA) && edges < 40) begin
      if (checkKeys)
        checkOutput($sformatf("%s_kidx_run%0d", tag, edges), useB ? keyIdxB : keyIdxA, nr - 1 - edges);
      @(negedge clk);
      edges++;
    end
    if (checkKeys) checkOutput({tag, "_kidx_done"}, useB ? keyIdxB : keyIdxA, nr);
    // the plaintext is handed off on the next edge: nr+1 edges after the accept edge
    checkOutput({tag, "_latency"}, edges + 1, nr + 1);
    checkOutput({tag, "_pt"}, useB ? outDataB : outDataA, pt);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_drained"}, useB ? outValidB : outValidA, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  nextIn, outCount, lastOut, readyBad, stableBad, seenOut, edges;
    bit  acceptNow;
    checksRun    = 0;
    checksPassed = 0;
    rstN = 1'b0;
    {flushA, inValidA, outReadyA, flushB, inValidB, outReadyB} = '0;
    inDataA = '0;
    inDataB = '0;
    for (int i = 0; i < 16; i++) begin rkA[i] = '0; rkB[i] = '0; end
    expandKey({KEY_C1, 128'h0}, 4, 1'b0);
    expandKey(KEY_C3, 8, 1'b1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rst_out_valid", outValidA, 0);
    checkOutput("rst_in_ready", inReadyA, 1);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_key_idx", keyIdxA, 10);
    checkOutput("rst_out_data", outDataA, 0);
    checkOutput("rst_key_idx_b", keyIdxB, 14);

    applyStimulus(1'b0, "c1", CT_C1, PT_C, 1'b0);

    expandKey({KEY_B, 128'h0}, 4, 1'b0);
    applyStimulus(1'b0, "appb", CT_B, PT_B, 1'b1);

    // Four distinct blocks streamed with in_valid and out_ready held high
    expandKey({KEY_C1, 128'h0}, 4, 1'b0);
    ptList[0] = 128'h0123456789abcdeffedcba9876543210;
    ptList[1] = 128'h00000000000000000000000000000000;
    ptList[2] = 128'hffffffffffffffffffffffffffffffff;
    ptList[3] = PT_B;
    for (int i = 0; i < 4; i++) ctList[i] = encryptA(ptList[i]);
    nextIn = 0; outCount = 0; lastOut = 0; readyBad = 0;
    @(negedge clk);
    inDataA = ctList[0]; inValidA = 1'b1; outReadyA = 1'b1;
    for (int cyc = 0; cyc < 80 && outCount < 4; cyc++) begin
      acceptNow = inValidA && inReadyA;
      if (outValidA) begin
        checkOutput($sformatf("b2b_pt%0d", outCount), outDataA, ptList[outCount]);
        if (outCount > 0) checkOutput($sformatf("b2b_period%0d", outCount), cyc - lastOut, 11);
        lastOut = cyc;
        outCount++;
      end
      if (busyA && !outValidA && inReadyA) readyBad++;
      @(posedge clk);
      @(negedge clk);
      if (acceptNow) begin
        nextIn++;
        if (nextIn < 4) inDataA = ctList[nextIn];
        else            inValidA = 1'b0;
      end
    end
    inValidA = 1'b0;
    checkOutput("b2b_count", outCount, 4);
    checkOutput("b2b_ready_in_run", readyBad, 0);

    // Backpressure: result must sit still for 7 stalled cycles, then leave once
    @(negedge clk);
    inDataA = CT_C1; inValidA = 1'b1; outReadyA = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inValidA = 1'b0;
    edges = 0;
    while (!outValidA && edges < 40) begin @(negedge clk); edges++; end
    checkOutput("bp_valid", outValidA, 1);
    stableBad = 0;
    for (int i = 0; i < 7; i++) begin
      if (!outValidA || outDataA !== PT_C || inReadyA) stableBad++;
      @(negedge clk);
    end
    checkOutput("bp_hold", stableBad, 0);
    checkOutput("bp_data", outDataA, PT_C);
    outReadyA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_single", outValidA, 0);
    checkOutput("bp_idle", busyA, 0);

    // Flush in the fifth RUN cycle, with a competing in_valid that must be ignored
    inDataA = CT_C1; inValidA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValidA = 1'b0;
    repeat (4) @(negedge clk);
    flushA = 1'b1; inValidA = 1'b1;
    #1;
    checkOutput("flush_in_ready_low", inReadyA, 0);
    @(posedge clk);
    @(negedge clk);
    flushA = 1'b0; inValidA = 1'b0;
    #1;
    checkOutput("flush_out_valid", outValidA, 0);
    checkOutput("flush_in_ready", inReadyA, 1);
    checkOutput("flush_busy", busyA, 0);
    checkOutput("flush_state", outDataA, 0);
    seenOut = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (outValidA) seenOut++; end
    checkOutput("flush_no_output", seenOut, 0);

    // Asynchronous reset pulse in the middle of a block
    inDataA = CT_C1; inValidA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValidA = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rstmid_busy", busyA, 0);
    checkOutput("rstmid_key_idx", keyIdxA, 10);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rstmid_in_ready", inReadyA, 1);
    seenOut = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (outValidA) seenOut++; end
    checkOutput("rstmid_no_output", seenOut, 0);

    applyStimulus(1'b0, "c1_again", CT_C1, PT_C, 1'b0);
    applyStimulus(1'b1, "c3", CT_C3, PT_C, 1'b1);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
